// File: rtl/restoring_divider32.sv
// ============================================================================
// restoring_divider32
//   Sequential unsigned restoring divider, one quotient bit per clock.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module restoring_divider32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_INIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q,     state_d;
  logic [WIDTH-1:0] rem_q,       rem_d;
  logic [WIDTH-1:0] qacc_q,      qacc_d;
  logic [WIDTH-1:0] divisor_q,   divisor_d;
  logic [CW-1:0]    cnt_q,       cnt_d;
  logic [WIDTH-1:0] quotient_q,  quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q,       dbz_d;

  logic [WIDTH:0]   shifted;
  logic             trial_ok;
  logic [WIDTH-1:0] trial_diff;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] qacc_step;

  // rem_acc < divisor always holds, so a successful trial fits in WIDTH bits.
  assign shifted    = {rem_q, qacc_q[WIDTH-1]};
  assign trial_ok   = (shifted >= {1'b0, divisor_q});
  assign trial_diff = shifted[WIDTH-1:0] - divisor_q;
  assign rem_step   = trial_ok ? trial_diff : shifted[WIDTH-1:0];
  assign qacc_step  = {qacc_q[WIDTH-2:0], trial_ok};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      qacc_q      <= '0;
      divisor_q   <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      qacc_q      <= qacc_d;
      divisor_q   <= divisor_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    qacc_d      = qacc_q;
    divisor_d   = divisor_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          divisor_d = divisor;
          if (divisor == '0) begin
            // Division by zero completes immediately with fixed results.
            state_d     = S_DONE;
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = S_RUN;
            rem_d   = '0;
            qacc_d  = dividend;
            cnt_d   = CNT_INIT;
            dbz_d   = 1'b0;
          end
        end
      end
      S_RUN: begin
        rem_d  = rem_step;
        qacc_d = qacc_step;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d     = S_DONE;
          quotient_d  = qacc_step;
          remainder_d = rem_step;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_restoring_divider32.sv
// ============================================================================
// tb_restoring_divider32
//   Directed and random checks of restoring_divider32 against plain / and %.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_restoring_divider32;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_assert = 0;
  int n_fail   = 0;

  restoring_divider32 #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // busy and done must never be high together
  always @(negedge clk) begin
    n_assert++;
    assert (!(busy === 1'b1 && done === 1'b1)) else begin
      n_fail++;
      $error("FAIL busy_done_overlap: observed busy=%b done=%b expected not both 1", busy, done);
    end
  end

  // Called #1 after the accept edge; counts edges until done and busy cycles seen.
  task automatic wait_done(inout int edges, inout int busy_cycles);
    while (done !== 1'b1 && edges < 100) begin
      if (busy === 1'b1) busy_cycles++;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    int          edges;
    int          bc;
    logic [31:0] exp_q;
    logic [31:0] exp_r;
    logic        exp_z;
    int          exp_edges;
    edges = 0;
    bc    = 0;
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    wait_done(edges, bc);
    if (b == 32'd0) begin
      exp_q = 32'hFFFF_FFFF; exp_r = a; exp_z = 1'b1; exp_edges = 0;
    end else begin
      exp_q = a / b; exp_r = a % b; exp_z = 1'b0; exp_edges = 32;
    end
    check({tag, "_q"},       quotient,    exp_q);
    check({tag, "_r"},       remainder,   exp_r);
    check({tag, "_dbz"},     div_by_zero, exp_z);
    check({tag, "_latency"}, edges,       exp_edges);
    check({tag, "_busycyc"}, bc,          exp_edges);
  endtask

  initial begin
    int          edges;
    int          bc;
    int          done_seen;
    logic [31:0] a;
    logic [31:0] b;

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q",    quotient, 0);
    check("rst_r",    remainder, 0);
    check("rst_dbz",  div_by_zero, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op("t1_100_7", 32'd100, 32'd7);
    @(posedge clk); #1;
    check("t1_idle_done", done, 0);

    do_op("t2_max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("t2_max_1",   32'hFFFF_FFFF, 32'd1);
    do_op("t3_5_9",     32'd5, 32'd9);
    do_op("t3_0_3",     32'd0, 32'd3);
    do_op("t4_1234_0",  32'd1234, 32'd0);
    do_op("t4_10_3",    32'd10, 32'd3);
    @(posedge clk); #1;

    // start pulsed mid-RUN must be ignored
    edges = 0; bc = 0;
    start = 1'b1; dividend = 32'd1000; divisor = 32'd10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      if (busy === 1'b1) bc++;
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b1; dividend = 32'd77; divisor = 32'd7;
    if (busy === 1'b1) bc++;
    @(posedge clk); #1;
    edges++;
    start = 1'b0;
    check("t5_busy_after_ignored", busy, 1);
    wait_done(edges, bc);
    check("t5_q",       quotient, 100);
    check("t5_r",       remainder, 0);
    check("t5_latency", edges, 32);
    check("t5_busycyc", bc, 32);
    do_op("t5_b2b", 32'd400, 32'd20);
    @(posedge clk); #1;

    // reset in the middle of RUN abandons the op
    start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_q",    quotient, 0);
    check("t6_r",    remainder, 0);
    check("t6_dbz",  div_by_zero, 0);
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_seen++;
    end
    check("t6_no_done", done_seen, 0);
    do_op("t6_50_6", 32'd50, 32'd6);

    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd1;
        1: begin a = $urandom_range(0, 1000); b = a + 32'd1 + $urandom_range(0, 5000); end
        2: begin a = a | 32'h8000_0000; b = b | 32'h8000_0000; end
        3: begin a = a | 32'h8000_0000; b = $urandom_range(1, 255); end
        4: b = 32'd0;
        5: b = b >> $urandom_range(1, 31);
        default: ;
      endcase
      do_op("rand", a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
